// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one word-organised memory port between the CPU
// load/store path and a debug/loader port. Each access runs IDLE -> ISSUE ->
// RESP. Ties are broken round-robin against the last served requester.
//
// state | meaning
// IDLE  | no access in flight; pick a requester
// ISSUE | memory port driven from the owner's held request
// RESP  | read data returned, owner completes, last_owner updated
module dmem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_half,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_misalign,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_owner_q, last_owner_d;

  logic cpu_misaligned;
  logic sel_cpu;
  logic in_issue;
  logic in_resp;
  logic wr_access;
  logic access_ok;
  logic cpu_resp;
  logic unused_addr_bits;

  // Upper address bits wrap silently; debug low bits are ignored.
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  // State, owner and round-robin history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: grant in IDLE, fixed ISSUE -> RESP -> IDLE sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && dbg_req) begin
          owner_d = (last_owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
          state_d = ST_ISSUE;
        end else if (cpu_req) begin
          owner_d = OWN_CPU;
          state_d = ST_ISSUE;
        end else if (dbg_req) begin
          owner_d = OWN_DBG;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port: driven from the owner's held request; reset suppresses any
  // write so an access caught by reset in ISSUE never commits.
  always_comb begin
    cpu_misaligned = cpu_half ? cpu_addr[0] : (cpu_addr[1:0] != 2'b00);
    sel_cpu        = (owner_q == OWN_CPU);
    in_issue       = (state_q == ST_ISSUE) && !reset;
    in_resp        = (state_q == ST_RESP) && !reset;
    wr_access      = sel_cpu ? cpu_we : dbg_we;
    access_ok      = sel_cpu ? !cpu_misaligned : 1'b1;

    mem_addr  = sel_cpu ? cpu_addr[ADDR_W+1:2] : dbg_addr[ADDR_W+1:2];
    mem_wdata = dbg_wdata;
    if (sel_cpu) begin
      mem_wdata = cpu_half ? {cpu_wdata[15:0], cpu_wdata[15:0]} : cpu_wdata;
    end

    mem_en = in_issue && access_ok;
    mem_be = 4'b0000;
    if (mem_en && wr_access) begin
      if (sel_cpu && cpu_half) begin
        mem_be = cpu_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        mem_be = 4'b1111;
      end
    end
  end

  // Completion side: responses only in the owner's RESP cycle, and only if
  // the requester is still asking (a dropped request is discarded).
  always_comb begin
    cpu_resp     = in_resp && sel_cpu && cpu_req;
    cpu_misalign = cpu_resp && cpu_misaligned;
    cpu_stall    = cpu_req && !((state_q == ST_RESP) && sel_cpu);
    cpu_rdata    = 32'h0;
    if (cpu_resp && !cpu_misaligned && !cpu_we) begin
      if (cpu_half) begin
        cpu_rdata = cpu_addr[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      end else begin
        cpu_rdata = mem_rdata;
      end
    end

    dbg_ack   = in_resp && !sel_cpu && dbg_req;
    dbg_rdata = (dbg_ack && !dbg_we) ? mem_rdata : 32'h0;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the processor's word-organised data memory. It shares the single memory port between the processor's load/store path (`lh`/`sh`, word accesses) and a debug/loader port, so memory can be preloaded and inspected without hierarchical pokes. It converts byte addresses to word indices, builds byte-lane enables, sign-extends halfword loads, and stalls the processor while its access is pending.

## Interface
- `ADDR_W`, 8: memory word-index width (depth = 2^ADDR_W words).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request, held until `cpu_stall` = 0.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_half` in 1: 1 = halfword (`lh`/`sh`), 0 = word.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data (halfword in [15:0]).
- `cpu_rdata` out 32: load result, valid in the CPU RESP cycle.
- `cpu_stall` out 1: processor must hold its state.
- `cpu_misalign` out 1: one-cycle pulse, misaligned CPU access rejected.
- `dbg_req` in 1: debug request, held until `dbg_ack`.
- `dbg_we` in 1: debug write.
- `dbg_addr` in 32: byte address, word-only access, [1:0] ignored.
- `dbg_wdata` in 32: debug write data.
- `dbg_rdata` out 32: debug read data, valid with `dbg_ack`.
- `dbg_ack` out 1: one-cycle completion pulse.
- `mem_en` out 1: memory access enable.
- `mem_be` out 4: byte write enables. Non-zero only when writing.
- `mem_addr` out ADDR_W: word index = byte address [ADDR_W+1:2].
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: memory read data, synchronous read, valid the cycle after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, RESP. `owner` register (CPU/DBG) and `last_owner` register.
- **IDLE**
  - One requester pending: grant it.
  - Both pending: grant the one that is not `last_owner` (round-robin).
  - On grant, latch `owner` and go to ISSUE. With no request, stay in IDLE.
- **ISSUE**
  - `mem_en` = 1. Address and data are taken combinationally from the owner's held request inputs.
  - Go to RESP.
- **RESP**
  - Owner completion; `last_owner` ← `owner`.
  - Always return to IDLE: no back-to-back grant from RESP.
- **CPU halfword**
  - Lane select is `cpu_addr[1]`.
  - Store: `mem_wdata` = {`cpu_wdata[15:0]`, `cpu_wdata[15:0]`}; `mem_be` = 4'b0011 when `cpu_addr[1]` = 0, 4'b1100 when 1.
  - Load: `cpu_rdata` = sign-extended `mem_rdata[15:0]` or `mem_rdata[31:16]`.
- **CPU word**
  - Store: `mem_be` = 4'b1111.
  - Load: `cpu_rdata` = `mem_rdata`.
- **Misalignment**
  - Misaligned when halfword with `cpu_addr[0]` = 1, or word with `cpu_addr[1:0]` ≠ 0.
  - Still sequenced IDLE→ISSUE→RESP, but `mem_en` = 0 in ISSUE.
  - In RESP: `cpu_misalign` = 1 and `cpu_rdata` = 0.
- **Address range**
  - Address bits above ADDR_W+1 are ignored: addresses wrap modulo 2^ADDR_W words, no error.
- **Protocol**
  - A requester dropping `req` mid-access is a protocol violation. The access still completes; the response is discarded.

## Timing
- **Output and register values**
  - `cpu_rdata` and `dbg_rdata` are combinational from `mem_rdata` and are 0 outside the owner's RESP cycle.
  - `cpu_stall` = `cpu_req` & ~(state = RESP & `owner` = CPU), combinational.
- **Reset**
  - State IDLE, `last_owner` = DBG, so the CPU wins the first tie.
  - Whenever state = IDLE (and therefore in the cycle after a reset edge): `mem_en`, `mem_be`, `dbg_ack`, `cpu_misalign` = 0; `cpu_rdata`, `dbg_rdata` = 0.
  - Reset mid-access aborts it: a write in ISSUE at the reset edge is not committed after that edge, and no ack or misalign pulse is produced.
- **Latency**
  - Request seen in IDLE at cycle n: ISSUE at n+1, RESP at n+2.
  - The memory write commits at the end of n+1. Read data, `dbg_ack`, and stall release occur in n+2.
  - Minimum access interval is 3 cycles; a new request is accepted in IDLE at n+3.
- **Losing requester**
  - Keeps waiting (CPU stays stalled).
  - Worst-case wait is one foreign access (3 cycles) plus its own access.

## Test plan
- **Debug preload:** `dbg` write 32'd10 @0x0, then 32'd3 @0x4.
  - `dbg_ack` at cycle n+2 each time; `mem_be` = 4'b1111 in ISSUE; `mem_addr` = 0 then 1.
  - Debug read @0x4 → `dbg_rdata` = 0x00000003.
- **CPU `sh` then `lh`:** mem[0] = 0x00000000; `sh` 0x8001 @0x2, then `lh` @0x2.
  - `sh`: `mem_be` = 4'b1100, mem[0] = 0x80010000.
  - `lh`: `cpu_rdata` = 0xFFFF8001, `cpu_stall` high for exactly 2 cycles.
- **Simultaneous requests from reset:** `cpu_req` and `dbg_req` both high continuously.
  - Grant order CPU, DBG, CPU, with RESP cycles at 2, 5, 8.
- **Misaligned CPU access:** `lh` @0x3.
  - `mem_en` never asserted; `cpu_misalign` pulses in RESP; `cpu_rdata` = 0; stall released.
- **Wrap:** CPU word store 0xDEADBEEF @ byte 0x400 with ADDR_W = 8.
  - `mem_addr` = 0; a debug read @0x0 returns 0xDEADBEEF.
- **Reset mid-access:** assert `reset` in a DBG ISSUE cycle of a write.
  - mem unchanged after that edge; outputs at reset values next cycle; no `dbg_ack`.
